// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter between the cpu instruction-fetch (I) and data (D) ports.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority, D over I.
module mem_arbiter #(
    parameter int unsigned n   = 16,
    parameter int unsigned LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_req,
    input  logic [n-1:0] i_addr,
    output logic [n-1:0] i_rdata,
    output logic         i_ack,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [n-1:0] d_addr,
    input  logic [n-1:0] d_wdata,
    output logic [n-1:0] d_rdata,
    output logic         d_ack,
    output logic         mem_en,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic [n-1:0] mem_rdata
);

    localparam int unsigned CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

    localparam logic OwnI = 1'b0;
    localparam logic OwnD = 1'b1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [n-1:0]  mem_addr_q, mem_addr_d;
    logic [n-1:0]  mem_wdata_q, mem_wdata_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [n-1:0]  i_rdata_q, i_rdata_d;
    logic [n-1:0]  d_rdata_q, d_rdata_d;
    logic          grant_d;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    // Under contention the port not served last wins; a lone requester always wins.
    always_comb begin
        if (i_req && d_req) begin
            grant_d = ~last_q;
        end else begin
            grant_d = d_req;
        end
    end
`else
    always_comb begin
        grant_d = d_req;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_d      = last_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    owner_d     = grant_d;
                    mem_en_d    = 1'b1;
                    mem_we_d    = (grant_d == OwnD) && d_we;
                    mem_addr_d  = (grant_d == OwnD) ? d_addr : i_addr;
                    mem_wdata_d = (grant_d == OwnD) ? d_wdata : '0;
                    state_d     = StIssue;
`ifdef MEM_ARB_RR_EN
                    last_d      = grant_d;
`endif
                end
            end
            StIssue: begin
                cnt_d   = CW'(1);
                state_d = StWait;
            end
            StWait: begin
                // Last wait cycle is the one where mem_rdata is valid for this access.
                if (cnt_q == CW'(LAT)) begin
                    cnt_d = '0;
                    if (owner_q == OwnD) begin
                        d_rdata_d = mem_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = mem_rdata;
                        i_ack_d   = 1'b1;
                    end
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            owner_q     <= OwnI;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= OwnI;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
